i2c_write_engine: RTL and testbench
===================================

// Module: i2c_write_engine
// PURPOSE
//  Byte-serial I2C master write engine, downstream of the AV register-config sequencer.
//  Accepts a 24-bit {SLAVE_ADDR, SUB_ADDR, DATA} word on a GO/END level handshake.
//  Emits START, 3 bytes MSB-first each followed by an ACK slot, then STOP on I2C_SCLK/I2C_SDAT.
//  Reports whether any ACK slot was NACKed. Runs on the system clock with an internal tick divider.
// PARAMETERS
//  CLK_Freq   50000000  system clock frequency, Hz
//  I2C_Freq   20000     SCL frequency, Hz; tick period DIV = CLK_Freq/(4*I2C_Freq) = 625 cycles
// PORTS
//  iCLK       in     1   system clock; only clock in the block
//  iRST_N     in     1   asynchronous, active-low reset
//  I2C_DATA   in     24  {slave addr incl. R/W=0, sub addr, data}; sampled only at accept
//  GO         in     1   level request; rising into IDLE starts a transfer
//  END        out    1   1 = transfer complete, ACK valid; held while GO stays high
//  ACK        out    1   1 = at least one NACK seen (SDA high in an ACK slot); 0 = all acked
//  BUSY       out    1   1 from accept until END rises
//  I2C_SCLK   out    1   SCL, driven push-pull; no clock stretching
//  I2C_SDAT   inout  1   SDA, open drain: drives 0 or Z, never 1
// BEHAVIOUR
//  Reset (async, immediate, including mid-transfer)
//   - I2C_SCLK=1, I2C_SDAT=Z, END=0, ACK=0, BUSY=0; divider cleared; state IDLE.
//  Tick
//   - 16-bit counter; tick pulses 1 cycle when count==DIV-1, then wraps to 0.
//   - Counter runs only while BUSY; cleared in IDLE so the first tick comes DIV cycles after accept.
//  Accept
//   - In IDLE with GO=1 and END=0: latch I2C_DATA into shift reg, clear NACK flag, BUSY=1, go START.
//  States (each advances on a tick)
//   - START: ph0 SDA=0 with SCL=1; ph1 SCL=0.
//   - BIT, 24 bits x 4 phases:
//     ph0 SCL=0, drive SDA = shift MSB (Z for 1);
//     ph1 SCL=1;
//     ph2 SCL=1 hold;
//     ph3 SCL=0, shift left.
//   - ACKS, after bits 8/16/24, same 4 phases with SDA=Z.
//     Sample SDA at ph2 tick; if 1, set NACK flag.
//     A NACK does not abort: all 3 bytes and STOP are always sent.
//   - STOP: ph0 SCL=0, SDA=0; ph1 SCL=1; ph2 SDA=Z.
//   - DONE: END=1, ACK=NACK flag, BUSY=0 in the same cycle.
//  Timing
//   - Transfer = 2+27*4+3 = 113 ticks.
//   - END rises 113*DIV cycles (+1 register stage) after accept.
//  Handshake
//   - END stays 1 while GO=1; no retrigger while END=1.
//   - GO=0 while END=1: END drops the next cycle and the engine returns to IDLE; ACK holds its value.
//   - GO falling mid-transfer is ignored; the transfer completes.
//   - GO held high continuously yields exactly one transfer.
//  Data hold
//   - I2C_DATA changes after accept have no effect.
//  Sampling and width rules
//   - SDA input passes through a 2-flop synchronizer before sampling.
//   - Phase counter 2b, bit counter 5b (0..26); no arithmetic overflow is possible.
// STRUCTURE
//  - Shared package i2c_pkg: state encodings (IDLE, START, BIT, ACKS, STOP, DONE),
//    phase constants, DIV computation function.
//  - Sub-module i2c_tick_gen (parameters CLK_Freq, I2C_Freq; inputs iCLK, iRST_N, enable;
//    output tick).
//  - Remainder: one FSM plus shift register in this module.
// TESTING
//  Bench uses an I2C slave model with a per-byte ACK/NACK control; DIV overridden to 4 for runtime.
//  1 Word 24'h34001A, slave acks all
//    -> START, bytes 0x34/0x00/0x1A on SCL rising edges, STOP; END=1, ACK=0 after 113 ticks.
//  2 Word 24'h40C301, slave NACKs address byte only
//    -> all 27 slots still clocked and STOP sent; END=1, ACK=1.
//  3 GO held high 1000 ticks after END
//    -> no second START; drop GO -> END=0 next cycle;
//       raise GO with 24'h400000 -> new transfer with ACK recomputed.
//  4 Assert iRST_N=0 mid bit 10 (SDA driven 0)
//    -> same-cycle I2C_SCLK=1, I2C_SDAT=Z, END=0, BUSY=0;
//       after release, no bus activity until GO.
//  5 Change I2C_DATA to 24'hFFFFFF one tick after accept
//    -> bus still shows the originally latched word.
//  6 Default parameters, measure SCL
//    -> high time 2*625 and period 2500 iCLK cycles;
//       SDA changes only while SCL=0 except at START/STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings and helpers for the I2C write engine: FSM states, phase
// numbering, bus-drive decode and the tick divider computation.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_ACKS  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  // Slots 0..26: eight data bits then one ACK slot, three times over.
  localparam logic [4:0] LAST_SLOT = 5'd26;

  typedef struct packed {
    logic scl;
    logic sda_oe;
  } bus_drive_t;

  function automatic int unsigned calc_div(int unsigned clk_freq, int unsigned i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

  function automatic logic is_ack_slot(logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

  // Pin levels for a given state/phase; sda_oe=1 pulls SDA low.
  function automatic bus_drive_t drive_for(logic [2:0] st, logic [1:0] ph, logic msb);
    bus_drive_t d;
    d.scl    = 1'b1;
    d.sda_oe = 1'b0;
    case (st)
      ST_START: begin
        d.scl    = (ph == PH0);
        d.sda_oe = 1'b1;
      end
      ST_BIT: begin
        d.scl    = (ph == PH1) || (ph == PH2);
        d.sda_oe = ~msb;
      end
      ST_ACKS: d.scl = (ph == PH1) || (ph == PH2);
      ST_STOP: begin
        d.scl    = (ph != PH0);
        d.sda_oe = (ph != PH2);
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_write_engine_if.sv
// GO/END request handshake between the register-config sequencer (master)
// and the I2C write engine (slave).
interface i2c_write_engine_if;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic        END;
  logic        ACK;
  logic        BUSY;

  modport master (output I2C_DATA, output GO, input END, input ACK, input BUSY);
  modport slave  (input I2C_DATA, input GO, output END, output ACK, output BUSY);
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick: one-cycle pulse every DIV cycles while enabled,
// held cleared when disabled so the first tick lands DIV cycles after enable.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_Freq = 50000000,
  parameter int unsigned I2C_Freq = 20000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DIV  = calc_div(CLK_Freq, I2C_Freq);
  localparam logic [15:0] TERM = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == TERM) cnt_d = '0;
    else                          cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == TERM);

endmodule

// File: rtl/i2c_write_engine.sv
// Byte-serial I2C master write: START, three MSB-first bytes each with an
// ACK slot, STOP; reports any NACK on ACK when END rises.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_Freq = 50000000,
  parameter int unsigned I2C_Freq = 20000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  i2c_write_engine_if.slave hs,
  output logic              I2C_SCLK,
  inout  wire               I2C_SDAT
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [4:0]  slot_q, slot_d;
  logic [23:0] shift_q, shift_d;
  logic        nack_q, nack_d;
  logic        end_q, end_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  bus_drive_t  drv_q, drv_d;
  logic        sda_meta_q, sda_sync_q;
  logic        tick;

  i2c_tick_gen #(
    .CLK_Freq (CLK_Freq),
    .I2C_Freq (I2C_Freq)
  ) u_tick (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .enable (busy_q),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    nack_d  = nack_q;
    end_d   = end_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (hs.GO && !end_q) begin
          shift_d = hs.I2C_DATA;
          nack_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
          phase_d = PH0;
          slot_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase_q == PH1) begin
            state_d = ST_BIT;
            phase_d = PH0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_BIT, ST_ACKS: begin
        if (tick) begin
          if (state_q == ST_ACKS && phase_q == PH2 && sda_sync_q) nack_d = 1'b1;
          if (phase_q == PH3) begin
            phase_d = PH0;
            if (state_q == ST_BIT) shift_d = {shift_q[22:0], 1'b0};
            if (slot_q == LAST_SLOT) begin
              state_d = ST_STOP;
            end else begin
              slot_d  = slot_q + 5'd1;
              state_d = is_ack_slot(slot_q + 5'd1) ? ST_ACKS : ST_BIT;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (phase_q == PH2) state_d = ST_DONE;
          else                phase_d = phase_q + 2'd1;
        end
      end
      ST_DONE: begin
        // END is held until GO drops, which also blocks a retrigger.
        if (!end_q) begin
          end_d  = 1'b1;
          ack_d  = nack_q;
          busy_d = 1'b0;
        end else if (!hs.GO) begin
          end_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pins are registered from the next state so they never glitch.
    drv_d = drive_for(state_d, phase_d, shift_d[23]);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH0;
      slot_q     <= '0;
      nack_q     <= 1'b0;
      end_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      drv_q      <= '{scl: 1'b1, sda_oe: 1'b0};
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      nack_q     <= nack_d;
      end_q      <= end_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      drv_q      <= drv_d;
      sda_meta_q <= I2C_SDAT;
      sda_sync_q <= sda_meta_q;
    end
  end

  always_ff @(posedge iCLK) begin
    shift_q <= shift_d;
  end

  assign I2C_SCLK = drv_q.scl;
  assign I2C_SDAT = drv_q.sda_oe ? 1'b0 : 1'bz;
  assign hs.END   = end_q;
  assign hs.ACK   = ack_q;
  assign hs.BUSY  = busy_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: slave model with per-byte ACK control, a
// timeline model of the expected bus/handshake checked every cycle.
module tb_i2c_write_engine;

  localparam int D    = 4;
  localparam int XFER = 113 * D;
  localparam int LAT  = XFER + 1;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  i2c_write_engine_if hs ();
  i2c_write_engine_if hs1 ();
  wire scl_w, sda_w, scl1_w, sda1_w;
  pullup (sda_w);
  pullup (sda1_w);
  logic slv_drv = 1'b0;
  assign sda_w = slv_drv ? 1'b0 : 1'bz;

  i2c_write_engine #(.CLK_Freq(16), .I2C_Freq(1)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .hs       (hs.slave),
    .I2C_SCLK (scl_w),
    .I2C_SDAT (sda_w)
  );

  i2c_write_engine dut_def (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .hs       (hs1.slave),
    .I2C_SCLK (scl1_w),
    .I2C_SDAT (sda1_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave and bus monitor: reacts 2 time units after each clock edge.
  logic [2:0]  nack_cfg = 3'b000;
  logic [26:0] cap = '0;
  int          fall_cnt = 0, rise_cnt = 0, start_cnt = 0;
  logic        in_xfer = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;

  always @(posedge iCLK) begin
    #2;
    if (!iRST_N) begin
      slv_drv = 1'b0;
      in_xfer = 1'b0;
    end else if (prev_scl && scl_w && prev_sda && !sda_w) begin
      in_xfer = 1'b1;
      fall_cnt = -1;
      rise_cnt = 0;
      start_cnt++;
    end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
      in_xfer = 1'b0;
    end else if (in_xfer && prev_scl && !scl_w) begin
      fall_cnt++;
      slv_drv = (fall_cnt == 8)  ? !nack_cfg[0] :
                (fall_cnt == 17) ? !nack_cfg[1] :
                (fall_cnt == 26) ? !nack_cfg[2] : 1'b0;
    end else if (in_xfer && !prev_scl && scl_w) begin
      if (rise_cnt < 27) cap = {cap[25:0], sda_w};
      rise_cnt++;
    end
    prev_scl = scl_w;
    prev_sda = sda_w;
  end

  // Reference model: a transfer is a fixed timeline of 113 phases of D cycles.
  logic [23:0] m_word = '0;
  logic [2:0]  m_nack = '0;
  int          m_k = 0;
  logic        m_active = 1'b0, m_end = 1'b0, m_ack = 1'b0, m_busy = 1'b0;

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      m_active = 1'b0; m_end = 1'b0; m_ack = 1'b0; m_busy = 1'b0; m_k = 0;
    end else if (m_end && !hs.GO) begin
      m_end = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k == LAT) begin
        m_active = 1'b0; m_end = 1'b1; m_busy = 1'b0; m_ack = |m_nack;
      end
    end else if (!m_end && hs.GO) begin
      m_active = 1'b1; m_k = 0; m_busy = 1'b1;
      m_word = hs.I2C_DATA; m_nack = nack_cfg;
    end
  end

  function automatic logic [1:0] exp_bus(int k, logic [23:0] w, logic [2:0] nk);
    int p, s, ph, bi, pos;
    logic [23:0] ws;
    logic [2:0]  ns;
    logic scl, sda;
    p = k / D; scl = 1'b1; sda = 1'b1;
    if (p < 2) begin
      scl = (p == 0); sda = 1'b0;
    end else if (p < 110) begin
      s = (p - 2) / 4; ph = (p - 2) % 4; bi = s / 9; pos = s % 9;
      ns = nk >> bi;
      scl = (ph == 1) || (ph == 2);
      if (pos == 8) begin
        sda = ns[0] || (ph == 3);
      end else begin
        ws = w << (bi * 8 + pos);
        sda = ws[23] && !(pos == 7 && ph == 3 && !ns[0]);
      end
    end else if (p < 113) begin
      ph = p - 110; scl = (ph != 0); sda = (ph == 2);
    end
    return {scl, sda};
  endfunction

  function automatic logic [26:0] mk_cap(logic [23:0] w, logic [2:0] nk);
    return {w[23:16], nk[0], w[15:8], nk[1], w[7:0], nk[2]};
  endfunction

  logic       chk_en = 1'b0;
  logic [1:0] eb;
  always @(negedge iCLK) begin
    if (chk_en) begin
      eb = (m_active && m_k < XFER) ? exp_bus(m_k, m_word, m_nack) : 2'b11;
      chk1("cyc_scl", scl_w, eb[1]);
      chk1("cyc_sda", sda_w, eb[0]);
      chk1("cyc_busy", hs.BUSY, m_busy);
      chk1("cyc_end", hs.END, m_end);
      chk1("cyc_ack", hs.ACK, m_ack);
    end
  end

  int cyc_cnt = 0;
  always @(posedge iCLK) cyc_cnt <= cyc_cnt + 1;

  task automatic run_xfer(input logic [23:0] w, input logic [2:0] nk, input int drop_at,
                          input int chg_at, output int lat);
    int n;
    n = 0;
    @(negedge iCLK);
    nack_cfg = nk; hs.I2C_DATA = w; hs.GO = 1'b1;
    while (hs.END !== 1'b1 && n < LAT + 20) begin
      @(negedge iCLK);
      n++;
      if (n == drop_at) hs.GO = 1'b0;
      if (n == chg_at)  hs.I2C_DATA = 24'hFFFFFF;
    end
    chk1("end_seen", hs.END, 1'b1);
    lat = n - 1;
  endtask

  task automatic post(input logic [23:0] w, input logic [2:0] nk, input int lat);
    chk32("end_latency", lat, LAT);
    chk1("ack_flag", hs.ACK, |nk);
    chk32("bus_bits", 32'(cap), 32'(mk_cap(w, nk)));
    chk32("scl_rises", rise_cnt, 28);
    chk1("stop_seen", in_xfer, 1'b0);
  endtask

  task automatic release_go();
    if (hs.GO) begin
      @(negedge iCLK);
      hs.GO = 1'b0;
    end
    @(negedge iCLK);
    chk1("end_drop", hs.END, 1'b0);
  endtask

  task automatic wait_scl1(input logic lvl, output int t);
    int n;
    n = 0;
    while (scl1_w !== lvl && n < 5000) begin
      @(negedge iCLK);
      n++;
    end
    chk1("scl_def_wait", scl1_w, lvl);
    t = cyc_cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, t0, tr1, tf1, tr2, drop;
    logic [23:0] w;
    logic [2:0]  nk;
    hs.GO = 1'b0;  hs.I2C_DATA = '0;
    hs1.GO = 1'b0; hs1.I2C_DATA = '0;
    repeat (3) @(negedge iCLK);
    chk1("rst_scl", scl_w, 1'b1);
    chk1("rst_sda", sda_w, 1'b1);
    chk1("rst_end", hs.END, 1'b0);
    chk1("rst_ack", hs.ACK, 1'b0);
    chk1("rst_busy", hs.BUSY, 1'b0);
    iRST_N = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge iCLK);

    run_xfer(24'h34001A, 3'b000, 0, 0, lat);
    post(24'h34001A, 3'b000, lat);
    chk32("t1_bits", 32'(cap), 32'({8'h34, 1'b0, 8'h00, 1'b0, 8'h1A, 1'b0}));
    chk1("t1_ack", hs.ACK, 1'b0);
    release_go();

    run_xfer(24'h40C301, 3'b001, 0, 0, lat);
    post(24'h40C301, 3'b001, lat);
    chk32("t2_bits", 32'(cap), 32'({8'h40, 1'b1, 8'hC3, 1'b0, 8'h01, 1'b0}));
    chk1("t2_ack", hs.ACK, 1'b1);
    release_go();

    w = 24'($urandom);
    run_xfer(w, 3'b100, 0, 0, lat);
    post(w, 3'b100, lat);
    s0 = start_cnt;
    repeat (1000 * D) @(negedge iCLK);
    chk32("hold_starts", start_cnt, s0);
    chk1("hold_end", hs.END, 1'b1);
    hs.GO = 1'b0;
    @(negedge iCLK);
    chk1("hold_drop_end", hs.END, 1'b0);
    chk1("hold_ack_kept", hs.ACK, 1'b1);
    run_xfer(24'h400000, 3'b000, 0, 0, lat);
    post(24'h400000, 3'b000, lat);
    release_go();

    run_xfer(24'hA55A0F, 3'b000, 2 * D, D + 1, lat);
    post(24'hA55A0F, 3'b000, lat);
    chk32("t5_bits", 32'(cap), 32'({8'hA5, 1'b0, 8'h5A, 1'b0, 8'h0F, 1'b0}));
    release_go();

    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom);
      nk = 3'($urandom_range(0, 7));
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 400)) : 0;
      run_xfer(w, nk, drop, 0, lat);
      post(w, nk, lat);
      release_go();
    end

    @(negedge iCLK);
    nack_cfg = 3'b000; hs.I2C_DATA = 24'h340000; hs.GO = 1'b1;
    @(negedge iCLK);
    hs.GO = 1'b0;
    repeat (46 * D + 1) @(negedge iCLK);
    chk1("pre_rst_scl", scl_w, 1'b0);
    chk1("pre_rst_sda", sda_w, 1'b0);
    #1 iRST_N = 1'b0;
    #1;
    chk1("mid_rst_scl", scl_w, 1'b1);
    chk1("mid_rst_sda", sda_w, 1'b1);
    chk1("mid_rst_end", hs.END, 1'b0);
    chk1("mid_rst_busy", hs.BUSY, 1'b0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    s0 = start_cnt;
    repeat (50) @(negedge iCLK);
    chk32("post_rst_starts", start_cnt, s0);

    w = 24'($urandom);
    run_xfer(w, 3'b010, 0, 0, lat);
    post(w, 3'b010, lat);
    release_go();

    chk1("def_idle_sda", sda1_w, 1'b1);
    @(negedge iCLK);
    hs1.I2C_DATA = 24'h34001A; hs1.GO = 1'b1;
    wait_scl1(1'b0, t0);
    wait_scl1(1'b1, tr1);
    wait_scl1(1'b0, tf1);
    wait_scl1(1'b1, tr2);
    chk32("def_scl_high", tf1 - tr1, 1250);
    chk32("def_scl_period", tr2 - tr1, 2500);
    hs1.GO = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
